// File: rtl/pulse_period_checker_if.sv
// Bundles the pulse-checker stimulus and status signals; the checker uses the slave view,
// the pulse source/monitor uses the master view.
interface pulse_period_checker_if #(
   parameter int unsigned CW = 8
);
   logic          start;
   logic          pulse_in;
   logic          locked;
   logic          err_early;
   logic          err_late;
   logic [CW-1:0] interval;
   logic [15:0]   good_cnt;

   modport master (
      output start, pulse_in,
      input  locked, err_early, err_late, interval, good_cnt
   );

   modport slave (
      input  start, pulse_in,
      output locked, err_early, err_late, interval, good_cnt
   );
endinterface

// File: rtl/pulse_period_checker.sv
// Checks that pulse_in repeats every PERIOD start-high cycles; locks after LOCK_N good
// intervals in a row and flags early or missing pulses for one cycle.
module pulse_period_checker #(
   parameter int unsigned PERIOD = 10,
   parameter int unsigned LOCK_N = 3,
   parameter int unsigned CW     = 8
) (
   input logic                   clk,
   input logic                   rst,
   pulse_period_checker_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

   localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);
   localparam logic [3:0]    LOCK_C   = 4'(LOCK_N);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [CW-1:0] interval_q, interval_n;
   logic [3:0]    run, run_n;
   logic [15:0]   good_q, good_n;
   logic          early_q, early_n;
   logic          late_q, late_n;
   logic          locked_q;
   logic          sampled;

   assign sampled = bus.start & bus.pulse_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         run        <= '0;
         interval_q <= '0;
         good_q     <= '0;
         early_q    <= 1'b0;
         late_q     <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         run        <= run_n;
         interval_q <= interval_n;
         good_q     <= good_n;
         early_q    <= early_n;
         late_q     <= late_n;
         locked_q   <= (state_n == LOCKED);
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      run_n      = run;
      interval_n = interval_q;
      good_n     = good_q;
      early_n    = 1'b0;
      late_n     = 1'b0;

      // start low freezes everything; only the one-cycle error flags drop back to 0
      if (bus.start) begin
         unique case (state)
            IDLE: begin
               if (sampled) begin
                  state_n = ACQ;
                  cnt_n   = CW'(1);
                  run_n   = '0;
               end
            end
            ACQ, LOCKED: begin
               if (sampled) begin
                  cnt_n = CW'(1);
                  if (cnt == PERIOD_C) begin
                     interval_n = PERIOD_C;
                     if (good_q != 16'hFFFF) good_n = good_q + 16'd1;
                     if (state == ACQ) begin
                        if (run + 4'd1 == LOCK_C) begin
                           state_n = LOCKED;
                           run_n   = '0;
                        end else begin
                           run_n = run + 4'd1;
                        end
                     end
                  end else begin
                     early_n    = 1'b1;
                     interval_n = cnt;
                     state_n    = ACQ;
                     run_n      = '0;
                  end
               end else if (cnt == PERIOD_C) begin
                  late_n  = 1'b1;
                  state_n = IDLE;
                  cnt_n   = '0;
                  run_n   = '0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               run_n   = '0;
            end
         endcase
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_early = early_q;
   assign bus.err_late  = late_q;
   assign bus.interval  = interval_q;
   assign bus.good_cnt  = good_q;

endmodule

// File: tb/tb_pulse_period_checker.sv
// Scoreboard bench for pulse_period_checker: a behavioural model predicts outputs per edge,
// plus directed checks of the locking, early, late, start-gating and reset scenarios.
module tb_pulse_period_checker;

   localparam int P  = 10;
   localparam int LN = 3;

   typedef struct packed {
      logic       locked;
      logic       early;
      logic       late;
      logic [7:0] interval;
      logic [15:0] good;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pulse_period_checker_if #(.CW(8)) bus ();

   pulse_period_checker #(.PERIOD(P), .LOCK_N(LN), .CW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   out_t exp_q[$];
   out_t obs_q[$];
   out_t cur;

   // reference model state: 0 = idle, 1 = acquiring, 2 = locked
   int m_state = 0, m_cnt = 0, m_run = 0, m_int = 0, m_good = 0;
   logic m_early = 1'b0, m_late = 1'b0;

   task automatic drive(input logic s, input logic p, input logic r);
      out_t e;
      bus.start    = s;
      bus.pulse_in = p;
      rst          = r;
      @(posedge clk);
      m_early = 1'b0;
      m_late  = 1'b0;
      if (r) begin
         m_state = 0; m_cnt = 0; m_run = 0; m_int = 0; m_good = 0;
      end else if (s) begin
         if (m_state == 0) begin
            if (p) begin m_state = 1; m_cnt = 1; m_run = 0; end
         end else if (p) begin
            if (m_cnt == P) begin
               m_int = P;
               if (m_good < 65535) m_good = m_good + 1;
               m_cnt = 1;
               if (m_state == 1) begin
                  m_run = m_run + 1;
                  if (m_run == LN) begin m_state = 2; m_run = 0; end
               end
            end else begin
               m_early = 1'b1; m_int = m_cnt; m_state = 1; m_run = 0; m_cnt = 1;
            end
         end else if (m_cnt == P) begin
            m_late = 1'b1; m_state = 0; m_cnt = 0; m_run = 0;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
      e.locked   = (m_state == 2);
      e.early    = m_early;
      e.late     = m_late;
      e.interval = 8'(m_int);
      e.good     = 16'(m_good);
      exp_q.push_back(e);
      #1;
      cur = {bus.locked, bus.err_early, bus.err_late, bus.interval, bus.good_cnt};
      obs_q.push_back(cur);
   endtask

   task automatic test_reset();
      out_t e, o;
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b1);
      total++;
      if (cur !== out_t'(0)) begin
         bad++;
         $display("FAIL reset_outputs: got l=%b ee=%b el=%b iv=%0d gc=%0d, want all 0",
                  cur.locked, cur.early, cur.late, cur.interval, cur.good);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL sb_reset: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=%b ee=%b el=%b iv=%0d gc=%0d",
                     o.locked, o.early, o.late, o.interval, o.good, e.locked, e.early, e.late, e.interval, e.good);
         end
      end
   endtask

   task automatic test_lock();
      out_t e, o;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0);
         drive(1'b1, 1'b1, 1'b0);
         if (k == 2) begin
            total++;
            if (cur.locked !== 1'b0) begin
               bad++;
               $display("FAIL lock_not_yet: got locked=%b want 0", cur.locked);
            end
         end
      end
      total++;
      if (cur !== out_t'({1'b1, 1'b0, 1'b0, 8'd10, 16'd3})) begin
         bad++;
         $display("FAIL lock_after_40: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=1 ee=0 el=0 iv=10 gc=3",
                  cur.locked, cur.early, cur.late, cur.interval, cur.good);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL sb_lock: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=%b ee=%b el=%b iv=%0d gc=%0d",
                     o.locked, o.early, o.late, o.interval, o.good, e.locked, e.early, e.late, e.interval, e.good);
         end
      end
   endtask

   task automatic test_early();
      out_t e, o;
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      total++;
      if (cur !== out_t'({1'b0, 1'b1, 1'b0, 8'd7, 16'd3})) begin
         bad++;
         $display("FAIL early_flag: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=0 ee=1 el=0 iv=7 gc=3",
                  cur.locked, cur.early, cur.late, cur.interval, cur.good);
      end
      drive(1'b1, 1'b0, 1'b0);
      total++;
      if (cur.early !== 1'b0) begin
         bad++;
         $display("FAIL early_one_cycle: got err_early=%b want 0", cur.early);
      end
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0);
         drive(1'b1, 1'b1, 1'b0);
      end
      total++;
      if (cur.locked !== 1'b1 || cur.good !== 16'd6) begin
         bad++;
         $display("FAIL relock: got locked=%b good=%0d want locked=1 good=6", cur.locked, cur.good);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL sb_early: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=%b ee=%b el=%b iv=%0d gc=%0d",
                     o.locked, o.early, o.late, o.interval, o.good, e.locked, e.early, e.late, e.interval, e.good);
         end
      end
   endtask

   task automatic test_late();
      out_t e, o;
      for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0);
      total++;
      if (cur.late !== 1'b0 || cur.locked !== 1'b1) begin
         bad++;
         $display("FAIL late_too_soon: got late=%b locked=%b want late=0 locked=1", cur.late, cur.locked);
      end
      drive(1'b1, 1'b0, 1'b0);
      total++;
      if (cur !== out_t'({1'b0, 1'b0, 1'b1, 8'd10, 16'd6})) begin
         bad++;
         $display("FAIL late_flag: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=0 ee=0 el=1 iv=10 gc=6",
                  cur.locked, cur.early, cur.late, cur.interval, cur.good);
      end
      drive(1'b1, 1'b0, 1'b0);
      total++;
      if (cur.late !== 1'b0) begin
         bad++;
         $display("FAIL late_one_cycle: got err_late=%b want 0", cur.late);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL sb_late: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=%b ee=%b el=%b iv=%0d gc=%0d",
                     o.locked, o.early, o.late, o.interval, o.good, e.locked, e.early, e.late, e.interval, e.good);
         end
      end
   endtask

   task automatic test_start_gate();
      out_t e, o;
      drive(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
      // start low with pulse_in high must be ignored entirely
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      total++;
      if (cur !== out_t'({1'b0, 1'b0, 1'b0, 8'd10, 16'd7})) begin
         bad++;
         $display("FAIL start_gate: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=0 ee=0 el=0 iv=10 gc=7",
                  cur.locked, cur.early, cur.late, cur.interval, cur.good);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL sb_start: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=%b ee=%b el=%b iv=%0d gc=%0d",
                     o.locked, o.early, o.late, o.interval, o.good, e.locked, e.early, e.late, e.interval, e.good);
         end
      end
   endtask

   task automatic test_reset_priority();
      out_t e, o;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0);
         drive(1'b1, 1'b1, 1'b0);
      end
      total++;
      if (cur.locked !== 1'b1 || cur.good !== 16'd9) begin
         bad++;
         $display("FAIL prelock: got locked=%b good=%0d want locked=1 good=9", cur.locked, cur.good);
      end
      rst = 1'b1;
      #2;
      rst = 1'b0;
      total++;
      if (bus.locked !== 1'b1 || bus.good_cnt !== 16'd9) begin
         bad++;
         $display("FAIL async_glitch: got locked=%b good=%0d want locked=1 good=9", bus.locked, bus.good_cnt);
      end
      drive(1'b1, 1'b1, 1'b1);
      total++;
      if (cur !== out_t'(0)) begin
         bad++;
         $display("FAIL rst_priority: got l=%b ee=%b el=%b iv=%0d gc=%0d want all 0",
                  cur.locked, cur.early, cur.late, cur.interval, cur.good);
      end
      drive(1'b1, 1'b1, 1'b0);
      total++;
      if (cur.early !== 1'b0 || cur.locked !== 1'b0) begin
         bad++;
         $display("FAIL post_rst_idle: got early=%b locked=%b want 0 0", cur.early, cur.locked);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL sb_rstprio: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=%b ee=%b el=%b iv=%0d gc=%0d",
                     o.locked, o.early, o.late, o.interval, o.good, e.locked, e.early, e.late, e.interval, e.good);
         end
      end
   endtask

   task automatic test_stuck_pulse();
      out_t e, o;
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      total++;
      if (cur.early !== 1'b0) begin
         bad++;
         $display("FAIL stuck_first: got err_early=%b want 0", cur.early);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         total++;
         if (cur !== out_t'({1'b0, 1'b1, 1'b0, 8'd1, 16'd0})) begin
            bad++;
            $display("FAIL stuck_early: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=0 ee=1 el=0 iv=1 gc=0",
                     cur.locked, cur.early, cur.late, cur.interval, cur.good);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin
            bad++;
            $display("FAIL sb_stuck: got l=%b ee=%b el=%b iv=%0d gc=%0d want l=%b ee=%b el=%b iv=%0d gc=%0d",
                     o.locked, o.early, o.late, o.interval, o.good, e.locked, e.early, e.late, e.interval, e.good);
         end
      end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.pulse_in = 1'b0;
      test_reset();
      test_lock();
      test_early();
      test_late();
      test_start_gate();
      test_reset_priority();
      test_stuck_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pulse_period_checker.md
PULSE_PERIOD_CHECKER -- requirements
Module: pulse_period_checker

Interface
REQ-001 The block SHALL have parameter PERIOD, default 10: expected cycles between consecutive pulse_in pulses, counting only cycles where start is high; legal range 2..2^CW-2.
REQ-002 The block SHALL have parameter LOCK_N, default 3: number of consecutive good intervals required to assert locked; legal range 1..15.
REQ-003 The block SHALL have parameter CW, default 8: width of the interval counter and of the interval output.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  enable; while low, the checker freezes and ignores pulse_in.
REQ-007 pulse_in  input  1  single-cycle pulse stream under check.
REQ-008 locked  output  1  registered; high while in LOCKED.
REQ-009 err_early  output  1  registered one-cycle flag: pulse arrived before PERIOD.
REQ-010 err_late  output  1  registered one-cycle flag: no pulse by PERIOD.
REQ-011 interval  output  CW  last measured interval, in start-high cycles.
REQ-012 good_cnt  output  16  count of good intervals since reset; saturates at 16'hFFFF.

Function
REQ-013 The block SHALL use a registered state machine with states IDLE (no reference pulse), ACQ (reference held, run < LOCK_N) and LOCKED.
REQ-014 The interval counter cnt SHALL be 0 in IDLE, load 1 on every accepted pulse, and increment by 1 on each start-high cycle without a pulse in ACQ/LOCKED.
REQ-015 Define a sampled pulse as an edge with start=1 and pulse_in=1; edges with start=0 SHALL change no state, counter, run counter or output except that err_early/err_late return to 0.
REQ-016 IDLE, sampled pulse: go to ACQ; cnt=1; run=0; interval and good_cnt unchanged; no error.
REQ-017 ACQ/LOCKED, sampled pulse with cnt==PERIOD (good): interval=PERIOD; good_cnt+1 (saturating); cnt=1.
REQ-018 ACQ, good pulse: run+1; if run+1==LOCK_N, go to LOCKED and run=0.
REQ-019 LOCKED, good pulse: stay in LOCKED.
REQ-020 ACQ/LOCKED, sampled pulse with cnt<PERIOD (early): err_early=1 for one cycle; interval=cnt; go to ACQ; run=0; cnt=1.
REQ-021 ACQ/LOCKED, start=1, pulse_in=0, cnt==PERIOD (missing): err_late=1 for one cycle; go to IDLE; cnt=0; run=0; interval unchanged.
REQ-022 cnt SHALL never exceed PERIOD; no wrap-around is reachable.
REQ-023 err_early and err_late SHALL never be high in the same cycle.
REQ-024 Every output SHALL update on the clock edge that samples the event (one-cycle latency); locked SHALL equal (state==LOCKED) registered.
REQ-025 good_cnt SHALL hold at 16'hFFFF once reached; no other counter saturation is required.

Reset
REQ-026 With rst=1 at a rising edge, the block SHALL go to IDLE with cnt=0, run=0, locked=0, err_early=0, err_late=0, interval=0 and good_cnt=0.
REQ-027 rst SHALL take priority over start and pulse_in; a pulse sampled together with rst SHALL be discarded.
REQ-028 Reset SHALL be synchronous only; asserting rst between edges SHALL have no effect on the outputs.

Verification
REQ-029 After reset, hold start=1 and pulse every 10 cycles (cycles 10,20,30,40) -> locked=1 after edge 40; good_cnt=3; interval=10; no error flags.
REQ-030 While locked, send a pulse 7 cycles after the previous one -> err_early=1 for one cycle; interval=7; locked=0; three further 10-cycle intervals -> locked=1 again.
REQ-031 While locked, omit one pulse -> err_late=1 for exactly one cycle, 10 start-cycles after the last pulse; locked=0; state IDLE; good_cnt unchanged.
REQ-032 Pull start low for 5 cycles mid-interval with no pulse, then resume; pulse arrives after 10 start-high cycles -> no error; interval=10.
REQ-033 Assert rst while locked, with pulse_in=1 on the same edge -> next cycle all outputs are 0 and state is IDLE.
REQ-034 Hold pulse_in=1 continuously with start=1 -> first edge enters ACQ; every later edge gives err_early=1 with interval=1; locked stays 0.
